// File: rtl/reg_bank_wr_arbiter_if.sv
// Bus bundle for reg_bank_wr_arbiter: packed write requests, grant/status
// outputs and the registered read port.
interface reg_bank_wr_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int NREGS = 8,
   parameter int WIDTH = 8
);
   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic [NREQ-1:0]       req;
   logic [NREQ*AW-1:0]    wr_addr;
   logic [NREQ*WIDTH-1:0] wr_data;
   logic [NREQ-1:0]       lock;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic                  wr_err;
   logic [AW-1:0]         rd_addr;
   logic [WIDTH-1:0]      rd_data;

   modport master (
      output req, wr_addr, wr_data, lock, rd_addr,
      input  gnt, busy, wr_err, rd_data
   );

   modport slave (
      input  req, wr_addr, wr_data, lock, rd_addr,
      output gnt, busy, wr_err, rd_data
   );
endinterface

// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin write arbiter in front of a shared register bank with one
// registered read port. Define ARB_LOCK_EN to enable locked burst grants.
module reg_bank_wr_arbiter #(
   parameter int NREQ  = 4,
   parameter int NREGS = 8,
   parameter int WIDTH = 8
) (
   input logic                 clk,
   input logic                 clr,
   reg_bank_wr_arbiter_if.slave bus
);
   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    ptr, ptr_nxt;
   logic [PW-1:0]    win, win_nxt;
   logic [PW-1:0]    pick;
   logic             found;
   int               idx;

   logic [AW-1:0]    addr_a [NREQ];
   logic [WIDTH-1:0] data_a [NREQ];
   logic [WIDTH-1:0] bank   [NREGS];
   logic [NREGS-1:0] we;
   logic [AW-1:0]    wa;
   logic [WIDTH-1:0] wd;
   logic             win_req;
   logic             win_ok;
   logic             hold;
   logic [WIDTH-1:0] rd_data_p1;

   function automatic logic in_range(input logic [AW-1:0] a);
      return int'(a) < NREGS;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
      return (int'(w) + 1 >= NREQ) ? '0 : PW'(int'(w) + 1);
   endfunction

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         addr_a[i] = bus.wr_addr[i*AW +: AW];
         data_a[i] = bus.wr_data[i*WIDTH +: WIDTH];
      end
   end

   // Round-robin search starting at ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   always_comb begin
      win_req = bus.req[win];
      wa      = addr_a[win];
      wd      = data_a[win];
      win_ok  = win_req && in_range(wa);
`ifdef ARB_LOCK_EN
      hold    = win_req && bus.lock[win];
`else
      hold    = 1'b0;
`endif
   end

`ifndef ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = ^bus.lock;
`endif

   always_comb begin
      state_nxt = state;
      win_nxt   = win;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = GRANT;
               win_nxt   = pick;
            end
         end
         GRANT: begin
            // A withdrawn request still consumes its turn.
            if (!hold) begin
               state_nxt = IDLE;
               ptr_nxt   = next_ptr(win);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.gnt    = '0;
      bus.busy   = (state == GRANT);
      bus.wr_err = (state == GRANT) && win_req && !in_range(wa);
      we         = '0;
      if (state == GRANT) begin
         bus.gnt[win] = 1'b1;
         if (win_ok && !clr) we[wa] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
         ptr   <= '0;
         win   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         win   <= win_nxt;
      end
   end

   // Bank update and read register; a same-cycle read sees the old word.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NREGS; i++) bank[i] <= '0;
         rd_data_p1 <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (we[i]) bank[i] <= wd;
         end
         rd_data_p1 <= in_range(bus.rd_addr) ? bank[bus.rd_addr] : '0;
      end
   end

   assign bus.rd_data = rd_data_p1;

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Directed bench for reg_bank_wr_arbiter (NREGS=6 so out-of-range addresses
// are representable); follows ARB_LOCK_EN when the build defines it.
module tb_reg_bank_wr_arbiter;
   localparam int NREQ  = 4;
   localparam int NREGS = 6;
   localparam int WIDTH = 8;
   localparam int AW    = 3;

   logic clk = 1'b0;
   logic clr;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   reg_bank_wr_arbiter_if #(.NREQ(NREQ), .NREGS(NREGS), .WIDTH(WIDTH)) bus();

   reg_bank_wr_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      bus.wr_addr[i*AW +: AW]       = a;
      bus.wr_data[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
      nxt();
      bus.rd_addr = a;
      nxt();
      smp();
      check_eq(tag, 32'(bus.rd_data), 32'(exp));
   endtask

   initial begin
      clr         = 1'b1;
      bus.req     = '0;
      bus.lock    = '0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;

      // Reset
      nxt();
      nxt();
      smp();
      check_eq("rst_gnt",    32'(bus.gnt),    32'h0);
      check_eq("rst_busy",   32'(bus.busy),   32'h0);
      check_eq("rst_wr_err", 32'(bus.wr_err), 32'h0);
      check_eq("rst_rd",     32'(bus.rd_data),32'h0);
      nxt();
      clr = 1'b0;
      for (int a = 0; a < 8; a++) rd_chk("rst_word", AW'(a), 8'h00);

      // Single write, latency to grant and to read data
      nxt();
      bus.req = 4'b0001;
      set_wr(0, 3'd3, 8'hA5);
      bus.rd_addr = 3'd3;
      smp();
      check_eq("lat_gnt_pre", 32'(bus.gnt), 32'h0);
      nxt();
      smp();
      check_eq("lat_gnt",  32'(bus.gnt),    32'h1);
      check_eq("lat_busy", 32'(bus.busy),   32'h1);
      check_eq("lat_err",  32'(bus.wr_err), 32'h0);
      nxt();
      bus.req = '0;
      smp();
      check_eq("lat_gnt_off", 32'(bus.gnt),     32'h0);
      check_eq("lat_rd_old",  32'(bus.rd_data), 32'h00);
      nxt();
      smp();
      check_eq("lat_rd_new", 32'(bus.rd_data), 32'hA5);

      // Round-robin with all requesters active
      nxt();
      clr = 1'b1;
      nxt();
      clr = 1'b0;
      for (int i = 0; i < 4; i++) set_wr(i, AW'(i), 8'(8'h11 * (i + 1)));
      bus.req = 4'b1111;
      for (int c = 0; c < 16; c++) begin
         nxt();
         if (c == 15) bus.req = '0;
         smp();
         check_eq("rr_gnt", 32'(bus.gnt), (c % 2 == 0) ? (32'h1 << ((c / 2) % 4)) : 32'h0);
      end
      rd_chk("rr_w0", 3'd0, 8'h11);
      rd_chk("rr_w1", 3'd1, 8'h22);
      rd_chk("rr_w2", 3'd2, 8'h33);
      rd_chk("rr_w3", 3'd3, 8'h44);

      // Out-of-range address at the NREGS boundary
      nxt();
      bus.req = 4'b0010;
      set_wr(1, 3'd6, 8'hEE);
      nxt();
      smp();
      check_eq("oor_gnt", 32'(bus.gnt),    32'h2);
      check_eq("oor_err", 32'(bus.wr_err), 32'h1);
      nxt();
      bus.req = '0;
      smp();
      check_eq("oor_err_off", 32'(bus.wr_err), 32'h0);
      rd_chk("oor_w1", 3'd1, 8'h22);
      rd_chk("oor_w5", 3'd5, 8'h00);
      rd_chk("oor_w6", 3'd6, 8'h00);

      // Last valid word
      nxt();
      bus.req = 4'b0100;
      set_wr(2, 3'd5, 8'h5A);
      nxt();
      smp();
      check_eq("top_gnt", 32'(bus.gnt),    32'h4);
      check_eq("top_err", 32'(bus.wr_err), 32'h0);
      nxt();
      bus.req = '0;
      rd_chk("top_w5", 3'd5, 8'h5A);

      // Read and write of the same word in the same cycle
      nxt();
      bus.req = 4'b1000;
      set_wr(3, 3'd2, 8'h3C);
      bus.rd_addr = 3'd2;
      nxt();
      smp();
      check_eq("rw_gnt",    32'(bus.gnt),     32'h8);
      check_eq("rw_rd_pre", 32'(bus.rd_data), 32'h33);
      nxt();
      bus.req = '0;
      smp();
      check_eq("rw_rd_old", 32'(bus.rd_data), 32'h33);
      nxt();
      smp();
      check_eq("rw_rd_new", 32'(bus.rd_data), 32'h3C);

      // Reset while granting
      nxt();
      bus.req = 4'b0001;
      set_wr(0, 3'd4, 8'h77);
      nxt();
      clr = 1'b1;
      smp();
      check_eq("cg_gnt", 32'(bus.gnt), 32'h1);
      nxt();
      clr = 1'b0;
      bus.req = '0;
      smp();
      check_eq("cg_gnt_off", 32'(bus.gnt),    32'h0);
      check_eq("cg_busy",    32'(bus.busy),   32'h0);
      check_eq("cg_err",     32'(bus.wr_err), 32'h0);
      check_eq("cg_rd",      32'(bus.rd_data),32'h0);
      rd_chk("cg_w4", 3'd4, 8'h00);
      rd_chk("cg_w2", 3'd2, 8'h00);

      // Lock handling
      nxt();
      bus.req  = 4'b0101;
      bus.lock = 4'b0001;
      set_wr(0, 3'd0, 8'hA0);
      set_wr(2, 3'd4, 8'hC4);
      nxt();
      smp();
      check_eq("lk_gnt0", 32'(bus.gnt), 32'h1);
`ifdef ARB_LOCK_EN
      for (int k = 1; k < 4; k++) begin
         nxt();
         set_wr(0, AW'(k), 8'(8'hA0 + k));
         if (k == 3) bus.lock = '0;
         smp();
         check_eq("lk_burst_gnt", 32'(bus.gnt), 32'h1);
      end
      nxt();
      bus.req = 4'b0100;
      smp();
      check_eq("lk_gap", 32'(bus.gnt), 32'h0);
      nxt();
      smp();
      check_eq("lk_gnt2", 32'(bus.gnt), 32'h4);
      nxt();
      bus.req = '0;
      rd_chk("lk_w0", 3'd0, 8'hA0);
      rd_chk("lk_w1", 3'd1, 8'hA1);
      rd_chk("lk_w2", 3'd2, 8'hA2);
      rd_chk("lk_w3", 3'd3, 8'hA3);
      rd_chk("lk_w4", 3'd4, 8'hC4);
`else
      nxt();
      bus.req = 4'b0100;
      smp();
      check_eq("lk_ignored", 32'(bus.gnt), 32'h0);
      nxt();
      smp();
      check_eq("lk_gnt2", 32'(bus.gnt), 32'h4);
      nxt();
      bus.req  = '0;
      bus.lock = '0;
      rd_chk("lk_w0", 3'd0, 8'hA0);
      rd_chk("lk_w1", 3'd1, 8'h00);
      rd_chk("lk_w4", 3'd4, 8'hC4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
